// File: rtl/vco_adc_sequencer.sv
// VCO-based ADC sequencer: optionally warms up the VCO, counts synchronized phase
// edges over a programmable window, and publishes the count with a valid/overrun handshake.
module vco_adc_sequencer #(
  parameter int SETTLE_W = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                phase_in,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                cont_i,
  input  logic [9:0]          oversample_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic                sample_ready_i,
  input  logic                clr_ovr_i,
  output logic                vco_enb_o,
  output logic [10:0]         sample_o,
  output logic                sample_valid_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int CNT_W = (SETTLE_W > 10) ? SETTLE_W : 10;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  state_t           state, state_nxt;
  logic             sync1, sync2, sync3, edge_det;
  logic [CNT_W-1:0] cyc_cnt, cyc_cnt_nxt;
  logic [9:0]       win_q, win_src, win_m1;
  logic             cont_q;
  logic             enter_count, load;
  logic [10:0]      edge_cnt;

  assign edge_det    = sync2 & ~sync3;
  assign win_src     = (state == IDLE) ? oversample_i : win_q;
  assign win_m1      = win_src - 10'd1;  // a window of 0 wraps to 1023, i.e. 1024 cycles
  assign enter_count = (state_nxt == COUNT) && (state != COUNT);
  assign load        = (state == DONE);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (settle_i != '0) ? SETTLE : COUNT;
      SETTLE:  if (stop_i) state_nxt = IDLE;
               else if (cyc_cnt == '0) state_nxt = COUNT;
      COUNT:   if (stop_i) state_nxt = IDLE;
               else if (cyc_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = (cont_q && !stop_i) ? COUNT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Down-counter holds the remaining cycles of the current phase, minus one.
  always_comb begin
    cyc_cnt_nxt = cyc_cnt;
    if (state_nxt == IDLE)
      cyc_cnt_nxt = '0;
    else if (state == IDLE && state_nxt == SETTLE)
      cyc_cnt_nxt = CNT_W'(settle_i - SETTLE_W'(1));
    else if (enter_count)
      cyc_cnt_nxt = CNT_W'(win_m1);
    else if (cyc_cnt != '0)
      cyc_cnt_nxt = cyc_cnt - 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      sync3          <= 1'b0;
      state          <= IDLE;
      cyc_cnt        <= '0;
      win_q          <= '0;
      cont_q         <= 1'b0;
      edge_cnt       <= '0;
      vco_enb_o      <= 1'b1;
      busy_o         <= 1'b0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      {sync3, sync2, sync1} <= {sync2, sync1, phase_in};
      state     <= state_nxt;
      cyc_cnt   <= cyc_cnt_nxt;
      vco_enb_o <= (state_nxt == IDLE);
      busy_o    <= (state_nxt != IDLE);

      if (state == IDLE && start_i) begin
        win_q  <= oversample_i;
        cont_q <= cont_i;
      end

      if (enter_count)
        edge_cnt <= '0;
      else if (state == COUNT)
        edge_cnt <= edge_cnt + {10'd0, edge_det};

      if (load)
        sample_o <= edge_cnt;

      if (load)
        sample_valid_o <= 1'b1;
      else if (sample_valid_o && sample_ready_i)
        sample_valid_o <= 1'b0;

      // Set beats clear when both happen in the same cycle.
      if (load && sample_valid_o && !sample_ready_i)
        overrun_o <= 1'b1;
      else if (clr_ovr_i)
        overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vco_adc_sequencer.sv
// Directed bench for vco_adc_sequencer: expected samples are queued when a conversion
// is launched and popped when the DUT publishes a sample.
module tb_vco_adc_sequencer;

  localparam int SETTLE_W = 8;

  logic                clk;
  logic                rst_n;
  logic                phase_in;
  logic                start_i, stop_i, cont_i;
  logic [9:0]          oversample_i;
  logic [SETTLE_W-1:0] settle_i;
  logic                sample_ready_i, clr_ovr_i;
  logic                vco_enb_o;
  logic [10:0]         sample_o;
  logic                sample_valid_o, busy_o, overrun_o;

  logic phase_gen, phase_man;
  int   half;
  int   gcnt;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   exp_q[$];

  vco_adc_sequencer #(.SETTLE_W(SETTLE_W)) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .phase_in      (phase_in),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .cont_i        (cont_i),
    .oversample_i  (oversample_i),
    .settle_i      (settle_i),
    .sample_ready_i(sample_ready_i),
    .clr_ovr_i     (clr_ovr_i),
    .vco_enb_o     (vco_enb_o),
    .sample_o      (sample_o),
    .sample_valid_o(sample_valid_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square-wave phase source, half period in clock cycles; half == 0 hands control to phase_man.
  assign phase_in = (half != 0) ? phase_gen : phase_man;

  initial begin
    phase_gen = 1'b0;
    gcnt      = 0;
    forever begin
      @(negedge clk);
      if (half == 0) begin
        phase_gen = 1'b0;
        gcnt      = 0;
      end else begin
        gcnt++;
        if (gcnt >= half) begin
          phase_gen = ~phase_gen;
          gcnt      = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_start(input int settle, input int osv, input logic cont);
    settle_i     = SETTLE_W'(settle);
    oversample_i = 10'(osv);
    cont_i       = cont;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
  endtask

  task automatic accept();
    sample_ready_i = 1'b1;
    tick();
    sample_ready_i = 1'b0;
  endtask

  task automatic expect_sample(input string tag, input int budget);
    int n = 0;
    int exp;
    while (sample_valid_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(sample_valid_o), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    check(tag, 32'(sample_o), exp);
  endtask

  initial begin
    int n;
    int seen;

    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; cont_i = 1'b0;
    oversample_i = '0; settle_i = '0; sample_ready_i = 1'b0; clr_ovr_i = 1'b0;
    phase_man = 1'b0; half = 0;
    repeat (3) tick();
    check("rst_vco_enb", 32'(vco_enb_o), 32'd1);
    check("rst_busy",    32'(busy_o), 32'd0);
    check("rst_valid",   32'(sample_valid_o), 32'd0);
    check("rst_sample",  32'(sample_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Edge detect lands on the last of 4 COUNT cycles: counted.
    exp_q.push_back(1);
    pulse_start(0, 4, 1'b0);
    tick(); phase_man = 1'b1;
    tick(); tick(); phase_man = 1'b0;
    tick(); tick();
    expect_sample("last_cycle_edge", 4);
    accept();
    repeat (4) tick();

    // Edge detect lands on the DONE cycle: not counted.
    exp_q.push_back(0);
    pulse_start(0, 4, 1'b0);
    tick(); tick(); phase_man = 1'b1;
    tick(); tick(); phase_man = 1'b0;
    tick();
    expect_sample("done_cycle_edge", 4);
    accept();
    check("accept_clears_valid", 32'(sample_valid_o), 32'd0);
    repeat (4) tick();

    // Overrun: continuous, ready low, first window empty, second window one edge.
    exp_q.push_back(0);
    exp_q.push_back(1);
    pulse_start(0, 8, 1'b1);
    repeat (9) tick();
    expect_sample("ovr_first", 0);
    phase_man = 1'b1;
    tick(); tick(); phase_man = 1'b0;
    repeat (6) tick();
    check("ovr_before_second", 32'(overrun_o), 32'd0);
    tick();
    check("ovr_set", 32'(overrun_o), 32'd1);
    expect_sample("ovr_newest", 0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("ovr_stop_busy", 32'(busy_o), 32'd0);
    clr_ovr_i = 1'b1;
    tick();
    clr_ovr_i = 1'b0;
    check("ovr_cleared", 32'(overrun_o), 32'd0);
    check("ovr_valid_kept", 32'(sample_valid_o), 32'd1);
    accept();
    check("ovr_accepted", 32'(sample_valid_o), 32'd0);

    // Reset during SETTLE, with start held during reset.
    pulse_start(20, 8, 1'b0);
    repeat (3) tick();
    check("settle_busy", 32'(busy_o), 32'd1);
    check("settle_vco_on", 32'(vco_enb_o), 32'd0);
    rst_n = 1'b0; start_i = 1'b1;
    tick();
    check("midrst_vco_enb", 32'(vco_enb_o), 32'd1);
    check("midrst_busy",    32'(busy_o), 32'd0);
    check("midrst_valid",   32'(sample_valid_o), 32'd0);
    check("midrst_sample",  32'(sample_o), 32'd0);
    check("midrst_overrun", 32'(overrun_o), 32'd0);
    rst_n = 1'b1; start_i = 1'b0;
    tick();
    check("postrst_busy", 32'(busy_o), 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (sample_valid_o === 1'b1) seen++;
    end
    check("postrst_no_sample", 32'(seen), 32'd0);

    // Single shot: settle 4, window 64, phase period 8.
    half = 4;
    repeat (20) tick();
    exp_q.push_back(8);
    pulse_start(4, 64, 1'b0);
    n = 0;
    while (vco_enb_o === 1'b0 && n < 2000) begin
      n++;
      tick();
    end
    check("single_vco_low_len", 32'(n), 32'd69);
    expect_sample("single", 4);
    repeat (3) tick();
    check("single_valid_hold", 32'(sample_valid_o), 32'd1);
    accept();
    check("single_accepted", 32'(sample_valid_o), 32'd0);

    // Start while busy is ignored, including its new window and cont values.
    exp_q.push_back(2);
    pulse_start(0, 16, 1'b0);
    oversample_i = 10'd4;
    cont_i       = 1'b1;
    n = 0;
    while (vco_enb_o === 1'b0 && n < 2000) begin
      start_i = (n == 3);
      n++;
      tick();
    end
    start_i = 1'b0;
    check("busy_start_len", 32'(n), 32'd17);
    expect_sample("busy_start", 4);
    repeat (5) tick();
    check("busy_start_idle", 32'(busy_o), 32'd0);
    accept();

    // Continuous: window 32, ready held high, sample every 33 cycles, then stop in COUNT.
    sample_ready_i = 1'b1;
    repeat (3) exp_q.push_back(4);
    pulse_start(2, 32, 1'b1);
    expect_sample("cont_0", 200);
    for (int k = 0; k < 2; k++) begin
      tick();
      n = 1;
      while (sample_valid_o !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      check("cont_period", 32'(n), 32'd33);
      check("cont_vco_on", 32'(vco_enb_o), 32'd0);
      expect_sample("cont_k", 0);
    end
    repeat (5) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("cont_stop_busy", 32'(busy_o), 32'd0);
    check("cont_stop_vco", 32'(vco_enb_o), 32'd1);
    seen = 0;
    repeat (40) begin
      tick();
      if (sample_valid_o === 1'b1) seen++;
    end
    check("cont_stop_no_sample", 32'(seen), 32'd0);
    sample_ready_i = 1'b0;

    // Zero parameters: no settle, 1024-cycle window, phase period 4.
    half = 2;
    repeat (10) tick();
    exp_q.push_back(256);
    pulse_start(0, 0, 1'b0);
    n = 0;
    while (vco_enb_o === 1'b0 && n < 3000) begin
      n++;
      tick();
    end
    check("zero_vco_low_len", 32'(n), 32'd1025);
    expect_sample("zero_params", 4);
    accept();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
